uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 164 ++++++++++++++++
 tb/tb_uart_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small transmit FIFO.
// Every serial bit spans exactly 8 baud_tick strobes; the FIFO accepts bytes on any clk edge.
//
// state   | meaning
// --------+----------------------------------------------
// S_IDLE  | line held high, waiting for a queued byte
// S_START | driving the start bit (0)
// S_DATA  | shifting out 8 data bits, LSB first
// S_STOP  | driving the stop bit (1), may chain next frame
module uart_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          baud_tick,
    input  logic [7:0]                    data,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ctr_q, ctr_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push, pop, fifo_nonempty;

    assign data_ready    = (count_q < DEPTH_C);
    assign fifo_nonempty = (count_q != '0);
    assign push          = data_valid && data_ready;
    assign fifo_count    = count_q;
    assign tx            = tx_q;
    assign busy          = (state_q != S_IDLE);

    // Storage is not reset: count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    // Pointers are PTR_W wide, so they wrap modulo the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ctr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    tx_d = 1'b1;
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        ctr_d   = '0;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (ctr_q == 3'd7) begin
                        tx_d    = shift_q[0];
                        bit_d   = '0;
                        ctr_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        ctr_d = ctr_q + 3'd1;
                    end
                end
                S_DATA: begin
                    if (ctr_q == 3'd7) begin
                        ctr_d = '0;
                        if (bit_q != 3'd7) begin
                            shift_d = {1'b0, shift_q[7:1]};
                            tx_d    = shift_q[1];
                            bit_d   = bit_q + 3'd1;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        ctr_d = ctr_q + 3'd1;
                    end
                end
                S_STOP: begin
                    if (ctr_q == 3'd7) begin
                        ctr_d = '0;
                        // Chaining straight into START keeps back-to-back frames gapless.
                        if (fifo_nonempty) begin
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            tx_d    = 1'b0;
                            state_d = S_START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        ctr_d = ctr_q + 3'd1;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    ctr_d   = '0;
                    bit_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a tick-level model predicts FIFO occupancy and frame timing,
// and a line monitor decodes every frame sample-by-sample against the queued bytes.
module tb_uart_tx;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       gen_tick = 1'b0;
    logic       man_tick = 1'b0;
    logic       baud_tick;
    logic [7:0] data = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx;
    logic       busy;
    logic [$clog2(DEPTH):0] fifo_count;

    assign baud_tick = gen_tick | man_tick;

    uart_tx #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_tick  (baud_tick),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int         m_cnt = 0;
    int         ticks_left = 0;
    logic       tick_prev = 1'b0;
    logic [7:0] exp_q[$];

    // Monitor state
    bit         mon_en = 1'b0;
    int         fpos = -1;
    int         tick_cnt = 0;
    int         starts[$];
    logic [9:0] cur_frame = 10'h3FF;
    bit         tick_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Free-running strobe with random spacing between pulses.
    initial begin
        int gap;
        gap = 0;
        forever begin
            @(posedge clk); #1;
            if (tick_en && gap == 0) begin
                gen_tick = 1'b1;
                gap = $urandom_range(1, 3);
            end else begin
                gen_tick = 1'b0;
                if (gap > 0) gap--;
            end
        end
    end

    // Model: a frame occupies 80 ticks; a new one may start on its last tick or any later tick.
    initial begin
        bit push, pop;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cnt = 0;
                ticks_left = 0;
                exp_q.delete();
                tick_prev = 1'b0;
            end else begin
                push = data_valid && (m_cnt < DEPTH);
                pop  = 1'b0;
                if (baud_tick) begin
                    if (ticks_left <= 1 && m_cnt > 0) begin
                        pop = 1'b1;
                        ticks_left = 80;
                    end else if (ticks_left > 0) begin
                        ticks_left--;
                    end
                end
                if (push) exp_q.push_back(data);
                m_cnt = m_cnt + int'(push) - int'(pop);
                tick_prev = baud_tick;
            end
        end
    end

    // Monitor: status outputs every cycle, serial line on every tick.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fpos = -1;
            end else if (mon_en) begin
                chk("fifo_count", 32'(fifo_count), m_cnt);
                chk("data_ready", 32'(data_ready), 32'(m_cnt < DEPTH));
                chk("busy", 32'(busy), 32'(ticks_left > 0));
                if (tick_prev) begin
                    tick_cnt++;
                    if (fpos < 0 && tx == 1'b0) begin
                        starts.push_back(tick_cnt);
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_frame: got frame start expected none at t=%0t", $time);
                            cur_frame = 10'h3FE;
                        end else begin
                            b = exp_q.pop_front();
                            cur_frame = {1'b1, b, 1'b0};
                        end
                        fpos = 0;
                    end
                    if (fpos >= 0) begin
                        chk("tx_bit", 32'(tx), 32'(cur_frame[fpos / 8]));
                        fpos++;
                        if (fpos == 80) fpos = -1;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        data = b;
        data_valid = 1'b1;
        cyc();
        data_valid = 1'b0;
    endtask

    task automatic ticks_off();
        tick_en = 1'b0;
        repeat (5) cyc();
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (!(m_cnt == 0 && ticks_left == 0 && fpos < 0) && k < 30000) begin
            cyc();
            k++;
        end
        chk("drain_in_time", 32'(k < 30000), 1);
    endtask

    initial begin
        int n0;
        // Reset values
        rst_n = 1'b0;
        repeat (3) cyc();
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fifo_count", 32'(fifo_count), 0);
        chk("rst_data_ready", 32'(data_ready), 1);
        mon_en = 1'b1;
        rst_n = 1'b1;

        // Single frame 0xA5, pushed on the first edge after reset release
        push_byte(8'hA5);
        chk("first_push_count", 32'(fifo_count), 1);
        tick_en = 1'b1;
        wait_drain();

        // Back-to-back frames with no idle gap
        ticks_off();
        n0 = starts.size();
        push_byte(8'h55);
        push_byte(8'h0F);
        tick_en = 1'b1;
        wait_drain();
        if (starts.size() >= n0 + 2)
            chk("back_to_back_gap", starts[n0 + 1] - starts[n0], 80);
        else
            chk("back_to_back_frames", starts.size() - n0, 2);

        // Fill with ticks stopped: 5th byte must be refused
        ticks_off();
        data_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data = 8'($urandom);
            cyc();
            if (i == 3) chk("ready_after_4", 32'(data_ready), 0);
        end
        data_valid = 1'b0;
        chk("full_count", 32'(fifo_count), DEPTH);
        chk("full_ready", 32'(data_ready), 0);
        tick_en = 1'b1;
        wait_drain();

        // Simultaneous push and pop at DEPTH-1
        ticks_off();
        for (int i = 0; i < DEPTH - 1; i++) push_byte(8'(8'h30 + i));
        data = 8'hC7;
        data_valid = 1'b1;
        man_tick = 1'b1;
        cyc();
        data_valid = 1'b0;
        man_tick = 1'b0;
        chk("push_pop_count", 32'(fifo_count), DEPTH - 1);
        tick_en = 1'b1;
        wait_drain();

        // Reset during data bit 3 with two bytes queued
        ticks_off();
        push_byte(8'h96);
        push_byte(8'h11);
        push_byte(8'h22);
        tick_en = 1'b1;
        begin
            int k;
            k = 0;
            while (!(fpos >= 33 && fpos <= 39) && k < 5000) begin
                cyc();
                k++;
            end
            chk("reach_bit3", 32'(k < 5000), 1);
        end
        chk("queued_before_reset", 32'(fifo_count), 2);
        rst_n = 1'b0;
        #1;
        chk("reset_tx", 32'(tx), 1);
        chk("reset_fifo_count", 32'(fifo_count), 0);
        chk("reset_busy", 32'(busy), 0);
        repeat (4) cyc();
        rst_n = 1'b1;
        n0 = starts.size();
        repeat (400) cyc();
        chk("no_frame_after_reset", starts.size(), n0);

        // Randomized offered traffic
        for (int i = 0; i < 300; i++) begin
            data = 8'($urandom);
            data_valid = ($urandom_range(0, 3) == 0);
            cyc();
        end
        data_valid = 1'b0;
        wait_drain();

        // Loopback-style byte set
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h3C);
        wait_drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        tick_en = 1'b0;
        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
